plot_scheduler: RTL

- Shares the single vga_adapter pixel-write port among NREQ sprite requesters, e.g. snake-head draw, tail erase and apple draw.
- Each requester asks for a filled XDIM x YDIM rectangle at (x,y) in a given colour.
- The scheduler arbitrates round-robin, latches the winner's rectangle and sweeps its pixels with internal column/row counters, one pixel per clock.
- It sits between the game FSM and vga_adapter and replaces the per-sprite draw/erase states and counter pairs in the top level.

---
 rtl/plot_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/plot_scheduler.sv
// Round-robin sharing of one VGA pixel-write port; sweeps a latched XDIM x YDIM rectangle at one pixel per clock.
// Latency: req seen in IDLE -> first plot 2 cycles later -> done XDIM*YDIM+2 cycles after that IDLE cycle.
// Backpressure: req is a held level; losers wait until the next IDLE. Define PLOT_SCHED_FIXED_PRIO_EN for fixed priority.
module plot_scheduler #(
    parameter int NREQ    = 3,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] rect_x_i,
    input  logic [7*NREQ-1:0] rect_y_i,
    input  logic [3*NREQ-1:0] rect_colour_i,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   done_o,
    output logic              busy_o,
    output logic [7:0]        vga_x_o,
    output logic [6:0]        vga_y_o,
    output logic [2:0]        vga_colour_o,
    output logic              plot_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int XW = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int YW = (YDIM > 1) ? $clog2(YDIM) : 1;
    localparam logic [8:0] XLIM = 9'(XSCREEN);
    localparam logic [7:0] YLIM = 8'(YSCREEN);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   win_q, win_d;
    logic [7:0]      bx_q, bx_d;
    logic [6:0]      by_q, by_d;
    logic [2:0]      col_q, col_d;
    logic [XW-1:0]   xc_q;
    logic [YW-1:0]   yc_q;
    logic [NREQ-1:0] grant_q, done_q;
    logic            busy_q;
    logic [PW-1:0]   base;
    logic [2*NREQ-1:0] req2;
    logic [NREQ-1:0] rot;
    logic [PW:0]     sum;
    logic            found;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;

`ifdef PLOT_SCHED_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   ptr_sum;

    always_comb begin
        ptr_sum = {1'b0, win_q} + (PW+1)'(1);
        ptr_d   = ptr_sum[PW-1:0];
        if (ptr_sum >= (PW+1)'(NREQ)) ptr_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  ptr_q <= '0;
        else if (state_q == S_DONE) ptr_q <= ptr_d;
    end

    assign base = ptr_q;
`endif

    // Rotate requests so bit 0 is the current priority holder, then map the hit back.
    always_comb begin
        req2  = {req_i, req_i} >> base;
        rot   = req2[NREQ-1:0];
        win_d = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
                win_d = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        bx_d  = '0;
        by_d  = '0;
        col_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == PW'(i)) begin
                bx_d  = rect_x_i[8*i +: 8];
                by_d  = rect_y_i[7*i +: 7];
                col_d = rect_colour_i[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            col_q   <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        win_q   <= win_d;
                        grant_q <= ONE << win_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bx_q    <= bx_d;
                    by_q    <= by_d;
                    col_q   <= col_d;
                    xc_q    <= '0;
                    yc_q    <= '0;
                    state_q <= S_DRAW;
                end
                S_DRAW: begin
                    if (xc_q == XW'(XDIM-1)) begin
                        xc_q <= '0;
                        if (yc_q == YW'(YDIM-1)) begin
                            yc_q    <= '0;
                            done_q  <= grant_q;
                            state_q <= S_DONE;
                        end else begin
                            yc_q <= yc_q + YW'(1);
                        end
                    end else begin
                        xc_q <= xc_q + XW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Widened sums so off-screen pixels are clipped rather than wrapping onto the screen.
    assign sum_x        = {1'b0, bx_q} + 9'(xc_q);
    assign sum_y        = {1'b0, by_q} + 8'(yc_q);
    assign vga_x_o      = sum_x[7:0];
    assign vga_y_o      = sum_y[6:0];
    assign vga_colour_o = col_q;
    assign plot_o       = (state_q == S_DRAW) && (sum_x < XLIM) && (sum_y < YLIM);
    assign grant_o      = grant_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;

endmodule
